// File: rtl/add_sub_seq_ctrl_if.sv
// Request/result bundle between a requester and the sequenced add/sub controller.
// master = requester side, slave = controller side.
interface add_sub_seq_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic         op;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   modport master (
      output start, op, a_in, b_in,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, result, cout, overflow
   );
endinterface

// File: rtl/add_sub_seq_ctrl.sv
// W-bit add/sub over one 4-bit slice, LS nibble first; done NIBBLES cycles after start.
// No backpressure: start is taken only in IDLE and ignored (not queued) while busy.
module add_sub_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   add_sub_seq_ctrl_if.slave    bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  a_sh, b_sh, acc, result_q;
   logic [IW-1:0] idx;
   logic          c, cout_q, ovf_q, done_q;
   logic          load, step, last;
   logic [4:0]    slice;

   // One nibble of A + B' + carry; bit 4 is the carry into the next nibble.
   assign slice = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, c};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (idx == LAST_IDX) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         acc      <= '0;
         idx      <= '0;
         c        <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= last;
         if (load) begin
            a_sh <= bus.a_in;
            b_sh <= bus.op ? ~bus.b_in : bus.b_in;
            c    <= bus.op;
            idx  <= '0;
         end else if (step) begin
            acc  <= {slice[3:0], acc[W-1:4]};
            a_sh <= a_sh >> 4;
            b_sh <= b_sh >> 4;
            c    <= slice[4];
            idx  <= idx + 1'b1;
            if (last) begin
               // On the last slice a_sh/b_sh[3] are the operand sign bits.
               result_q <= {slice[3:0], acc[W-1:4]};
               cout_q   <= slice[4];
               ovf_q    <= (a_sh[3] == b_sh[3]) && (slice[3] != a_sh[3]);
            end
         end
      end
   end

   assign bus.busy     = (state == RUN);
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// Directed + swept check of add_sub_seq_ctrl at NIBBLES=4 and NIBBLES=2 with a result scoreboard.
module tb_add_sub_seq_ctrl;
   logic clk = 1'b0;
   logic rst4, rst2;
   always #5 clk = ~clk;

   add_sub_seq_ctrl_if #(.NIBBLES(4)) bus4();
   add_sub_seq_ctrl_if #(.NIBBLES(2)) bus2();

   add_sub_seq_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
   add_sub_seq_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

   typedef struct packed {
      logic [15:0] res;
      logic        co;
      logic        ov;
   } exp_t;

   exp_t        sbq[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] last_res4 = '0;
   logic [15:0] last_res2 = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference built from signed/unsigned integer arithmetic, independent of the slice scheme.
   function automatic exp_t model(input int w, input bit op, input int a, input int b);
      exp_t e;
      int m, sa, sb, r;
      m  = 1 << w;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      r  = op ? sa - sb : sa + sb;
      e.ov  = (r >= m / 2) || (r < -(m / 2));
      e.co  = op ? (a >= b) : (a + b >= m);
      e.res = 16'(op ? (a - b + m) % m : (a + b) % m);
      return e;
   endfunction

   task automatic drive(input int n, input bit s, input bit op, input int a, input int b);
      if (n == 4) begin
         bus4.start = s; bus4.op = op; bus4.a_in = 16'(a); bus4.b_in = 16'(b);
      end else begin
         bus2.start = s; bus2.op = op; bus2.a_in = 8'(a); bus2.b_in = 8'(b);
      end
   endtask

   function automatic logic dn(input int n);
      return (n == 4) ? bus4.done : bus2.done;
   endfunction

   function automatic logic bz(input int n);
      return (n == 4) ? bus4.busy : bus2.busy;
   endfunction

   function automatic exp_t outs(input int n);
      exp_t g;
      if (n == 4) g = {bus4.result, bus4.cout, bus4.overflow};
      else        g = {8'h00, bus2.result, bus2.cout, bus2.overflow};
      return g;
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
   task automatic do_op(input int n, input bit op, input int a, input int b, input string tag);
      exp_t        e, g;
      int          lat;
      logic [15:0] held;
      held = (n == 4) ? last_res4 : last_res2;
      sbq.push_back(model(4 * n, op, a, b));
      drive(n, 1'b1, op, a, b);
      @(posedge clk);
      @(negedge clk);
      drive(n, 1'b0, op, a, b);
      check({tag, " busy"}, 32'(bz(n)), 32'd1);
      lat = 0;
      while (!dn(n) && lat < 20) begin
         g = outs(n);
         check({tag, " hold"}, 32'(g.res), 32'(held));
         @(negedge clk);
         lat++;
      end
      check({tag, " lat"}, lat, n);
      check({tag, " idle"}, 32'(bz(n)), 32'd0);
      e = sbq.pop_front();
      g = outs(n);
      check({tag, " res"}, 32'(g.res), 32'(e.res));
      check({tag, " cout"}, 32'(g.co), 32'(e.co));
      check({tag, " ovf"}, 32'(g.ov), 32'(e.ov));
      if (n == 4) last_res4 = e.res;
      else        last_res2 = e.res;
   endtask

   initial begin
      exp_t e, g;
      int   dcnt, dlat;
      int   bl[20] = '{0, 17, 34, 51, 68, 85, 102, 119, 136, 153,
                       170, 187, 204, 221, 238, 255, 1, 127, 128, 254};

      rst4 = 1'b1;
      rst2 = 1'b1;
      drive(4, 1'b0, 1'b0, 0, 0);
      drive(2, 1'b0, 1'b0, 0, 0);
      #1;
      g = outs(4);
      check("rst res", 32'(g.res), 32'd0);
      check("rst cout", 32'(g.co), 32'd0);
      check("rst ovf", 32'(g.ov), 32'd0);
      check("rst busy", 32'(bz(4)), 32'd0);
      check("rst done", 32'(dn(4)), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst4 = 1'b0;
      rst2 = 1'b0;
      @(negedge clk);

      do_op(4, 1'b0, 16'h1234, 16'h0FFF, "add1");
      @(negedge clk);
      check("add1 done pulse", 32'(dn(4)), 32'd0);
      do_op(4, 1'b1, 16'h0005, 16'h0007, "sub5-7");
      do_op(4, 1'b1, 16'h0007, 16'h0005, "sub7-5");
      do_op(4, 1'b0, 16'h7FFF, 16'h0001, "add7fff");
      do_op(4, 1'b0, 16'hFFFF, 16'h0001, "addffff");
      do_op(4, 1'b1, 16'h8000, 16'h0001, "sub8000");
      check("sub8000 direct", 32'(last_res4), 32'h7FFF);
      @(negedge clk);

      // start held high with changing operands during RUN
      sbq.push_back(model(16, 1'b0, 16'h1111, 16'h2222));
      drive(4, 1'b1, 1'b0, 16'h1111, 16'h2222);
      @(posedge clk);
      @(negedge clk);
      dcnt = 0;
      dlat = 0;
      for (int i = 1; i <= 10; i++) begin
         drive(4, (i <= 3), 1'b1, 16'hAAAA, 16'h5555);
         @(negedge clk);
         if (dn(4)) begin
            dcnt++;
            dlat = i;
            e = sbq.pop_front();
            g = outs(4);
            check("held res", 32'(g.res), 32'(e.res));
         end
      end
      check("held done count", dcnt, 1);
      check("held lat", dlat, 4);
      last_res4 = 16'h3333;

      // back-to-back: second start issued in the done cycle of the first
      do_op(4, 1'b0, 16'h1000, 16'h0234, "b2b first");
      do_op(4, 1'b1, 16'h0100, 16'h0001, "b2b second");
      @(negedge clk);

      // async reset mid-RUN after two slices
      drive(4, 1'b1, 1'b0, 16'h1111, 16'h1111);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst4 = 1'b1;
      #1;
      g = outs(4);
      check("mid rst res", 32'(g.res), 32'd0);
      check("mid rst cout", 32'(g.co), 32'd0);
      check("mid rst busy", 32'(bz(4)), 32'd0);
      check("mid rst done", 32'(dn(4)), 32'd0);
      @(negedge clk);
      rst4 = 1'b0;
      last_res4 = '0;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (dn(4)) dcnt++;
      end
      check("mid rst no done", dcnt, 0);
      do_op(4, 1'b0, 16'h0001, 16'h0001, "post rst add");

      // NIBBLES=2 sweep: every a against a spread of b values, both ops
      for (int op = 0; op < 2; op++)
         for (int a = 0; a < 256; a++)
            for (int bi = 0; bi < 20; bi++)
               do_op(2, op[0], a, bl[bi], "sweep");
      @(negedge clk);
      check("sweep done pulse", 32'(dn(2)), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
